sha256_msg_sched: RTL

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_msg_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_sched
//  Description : SHA-256 message schedule. Buffers one 16-word block, then
//                produces W_0..W_63 one per controller round strobe using a
//                16-word sliding window.
//                Optional macro SHA256_MSCHED_BSWAP_EN byte-reverses every
//                incoming word before it is stored (little-endian host).
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_msg_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        blk_ready,
  input  logic        init_regs,
  input  logic        round_en,
  output logic [31:0] w_out,
  output logic [5:0]  w_idx,
  output logic        sched_err
);

  localparam logic [1:0] C_ST_EMPTY = 2'd0;
  localparam logic [1:0] C_ST_FULL  = 2'd1;
  localparam logic [1:0] C_ST_RUN   = 2'd2;

  localparam logic [5:0] C_LAST_T   = 6'd63;
  localparam logic [3:0] C_LAST_WR  = 4'd15;

  logic [1:0]  state_q, state_d;
  logic [31:0] window_q [16];
  logic [3:0]  wr_cnt_q;
  logic [5:0]  t_q;
  logic        err_q;

  logic        w_xfer;
  logic        w_advance;
  logic [31:0] w_wr_word;
  logic [31:0] w_new_word;

  function automatic logic [31:0] f_sig0(input logic [31:0] x);
    return ((x >> 7)  | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_sig1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  // Only the stored value differs between builds; handshake timing is shared.
`ifdef SHA256_MSCHED_BSWAP_EN
  assign w_wr_word = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
  assign w_wr_word = in_word;
`endif

  // Words are only taken while filling; strobes outside FULL/RUN do nothing.
  assign w_xfer     = (state_q == C_ST_EMPTY) && in_valid;
  assign w_advance  = round_en && ((state_q == C_ST_FULL) || (state_q == C_ST_RUN));
  assign w_new_word = f_sig1(window_q[14]) + window_q[9] + f_sig0(window_q[1]) + window_q[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= C_ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state decode: fill, wait for controller, run 64 rounds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_EMPTY: if (w_xfer && (wr_cnt_q == C_LAST_WR)) state_d = C_ST_FULL;
      C_ST_FULL:  if (round_en) state_d = C_ST_RUN;
      C_ST_RUN:   if (round_en && (t_q == C_LAST_T)) state_d = C_ST_EMPTY;
      default:    state_d = C_ST_EMPTY;
    endcase
  end

  // Handshake outputs depend on state only.
  always_comb begin
    in_ready  = 1'b0;
    blk_ready = 1'b0;
    case (state_q)
      C_ST_EMPTY: in_ready  = 1'b1;
      C_ST_FULL:  blk_ready = 1'b1;
      default: ;
    endcase
  end

  // Window: written in place while filling, shifted down by one per advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) window_q[i] <= '0;
    end else if (w_xfer) begin
      window_q[wr_cnt_q] <= w_wr_word;
    end else if (w_advance) begin
      for (int i = 0; i < 15; i++) window_q[i] <= window_q[i+1];
      window_q[15] <= w_new_word;
    end
  end

  // Fill pointer; the natural 4-bit wrap clears it after the 16th word.
  always_ff @(posedge clk) begin
    if (rst)         wr_cnt_q <= '0;
    else if (w_xfer) wr_cnt_q <= wr_cnt_q + 4'd1;
  end

  // Round index; the 6-bit wrap returns it to 0 after round 63.
  always_ff @(posedge clk) begin
    if (rst)                                         t_q <= '0;
    else if (w_advance)                              t_q <= t_q + 6'd1;
    else if (init_regs && (state_q == C_ST_FULL))    t_q <= '0;
  end

  // Sticky error: a round strobe arrived with no block buffered.
  always_ff @(posedge clk) begin
    if (rst)                                        err_q <= 1'b0;
    else if (round_en && (state_q == C_ST_EMPTY))   err_q <= 1'b1;
  end

  assign w_out     = window_q[0];
  assign w_idx     = t_q;
  assign sched_err = err_q;

endmodule
`default_nettype wire
